// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: snoops register writeback to derive a sticky PASS/FAIL/timeout verdict.
// Optional watchdog built only when TEST_MON_WATCHDOG_EN is defined (and TIMEOUT > 0).
module riscv_test_monitor #(
    parameter int XLEN     = 64,
    parameter int TNUM_REG = 3,
    parameter int DONE_REG = 26,
    parameter int PASS_REG = 27,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we,
    input  logic [4:0]       wb_waddr,
    input  logic [XLEN-1:0]  wb_wdata,
    input  logic             retire,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  fail_testnum,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

    state_t           r_state, w_state_nxt;
    logic [XLEN-1:0]  r_tnum, r_pass, r_fail_tnum;
    logic [CNT_W-1:0] r_cycle, r_retire;

    logic w_run, w_wr, w_done_wr, w_pass_ok, w_wd_hit, w_to_fail;

    assign w_run     = (r_state == S_RUN);
    // x0 is hardwired zero in the core, so writes to it never reach a shadow
    assign w_wr      = wb_we && (wb_waddr != 5'd0);
    assign w_done_wr = w_wr && (wb_waddr == 5'(DONE_REG)) && (wb_wdata == XLEN'(1));
    assign w_pass_ok = (r_pass == XLEN'(1));

`ifdef TEST_MON_WATCHDOG_EN
    localparam bit WD_EN  = (TIMEOUT > 0);
    localparam int WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    assign w_wd_hit = WD_EN && (r_cycle == CNT_W'(WD_LIM));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_wd_hit = 1'b0;
`endif

    // A DONE==1 write takes priority over a coincident watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_RUN) begin
            if (w_done_wr)
                w_state_nxt = w_pass_ok ? S_PASS : S_FAIL;
            else if (w_wd_hit)
                w_state_nxt = S_TMO;
        end
    end

    assign w_to_fail = w_run && ((w_state_nxt == S_FAIL) || (w_state_nxt == S_TMO));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tnum      <= '0;
            r_pass      <= '0;
            r_fail_tnum <= '0;
        end else if (w_run) begin
            if (w_wr && (wb_waddr == 5'(TNUM_REG)))
                r_tnum <= wb_wdata;
            if (w_wr && (wb_waddr == 5'(PASS_REG)))
                r_pass <= wb_wdata;
            if (w_to_fail)
                r_fail_tnum <= r_tnum;
        end
    end

    // Counters include the verdict cycle and saturate rather than wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle  <= '0;
            r_retire <= '0;
        end else if (w_run) begin
            if (r_cycle != '1)
                r_cycle <= r_cycle + 1'b1;
            if (retire && (r_retire != '1))
                r_retire <= r_retire + 1'b1;
        end
    end

    assign done         = (r_state != S_RUN);
    assign pass         = (r_state == S_PASS);
    assign fail         = (r_state == S_FAIL) || (r_state == S_TMO);
    assign timeout      = (r_state == S_TMO);
    assign fail_testnum = r_fail_tnum;
    assign cycle_cnt    = r_cycle;
    assign retire_cnt   = r_retire;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed + randomized bench for riscv_test_monitor against a verdict-level reference model.
module tb_riscv_test_monitor;

    localparam int XLEN    = 64;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 50;
`ifdef TEST_MON_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wb_we = 1'b0;
    logic [4:0]       wb_waddr = '0;
    logic [XLEN-1:0]  wb_wdata = '0;
    logic             retire = 1'b0;
    logic             done, pass, fail, timeout;
    logic [XLEN-1:0]  fail_testnum;
    logic [CNT_W-1:0] cycle_cnt, retire_cnt;

    riscv_test_monitor #(
        .XLEN(XLEN), .TNUM_REG(3), .DONE_REG(26), .PASS_REG(27),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata), .retire(retire), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .fail_testnum(fail_testnum),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: verdict 0=undecided 1=pass 2=fail 3=timeout
    logic [63:0] m_tnum, m_passf, m_ftn, m_cyc, m_ret;
    int          m_verdict;
    logic [63:0] sv_cyc, sv_ret;

    task automatic m_reset();
        m_tnum = 0; m_passf = 0; m_ftn = 0; m_cyc = 0; m_ret = 0; m_verdict = 0;
    endtask

    task automatic m_edge(input bit we, input logic [4:0] a, input logic [63:0] d, input bit r);
        if (m_verdict != 0) return;
        if (we && a == 5'd26 && d == 64'd1) begin
            m_verdict = (m_passf == 64'd1) ? 1 : 2;
            if (m_verdict == 2) m_ftn = m_tnum;
        end else if (WD && m_cyc == 64'(TIMEOUT - 1)) begin
            m_verdict = 3;
            m_ftn = m_tnum;
        end
        if (we && a == 5'd3)  m_tnum  = d;
        if (we && a == 5'd27) m_passf = d;
        if (m_cyc < 64'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (r && m_ret < 64'hFFFF_FFFF) m_ret = m_ret + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_done"},    64'(done),    64'(m_verdict != 0));
        chk({tag, "_pass"},    64'(pass),    64'(m_verdict == 1));
        chk({tag, "_fail"},    64'(fail),    64'(m_verdict >= 2));
        chk({tag, "_timeout"}, 64'(timeout), 64'(m_verdict == 3));
        chk({tag, "_ftn"},     fail_testnum, m_ftn);
        chk({tag, "_cyc"},     64'(cycle_cnt),  m_cyc);
        chk({tag, "_ret"},     64'(retire_cnt), m_ret);
    endtask

    // One cycle: drive at negedge, model updates at posedge, sample 1 time unit later
    task automatic step(input bit we, input logic [4:0] a, input logic [63:0] d, input bit r,
                        input string tag);
        wb_we = we; wb_waddr = a; wb_wdata = d; retire = r;
        @(posedge clk);
        m_edge(we, a, d, r);
        #1;
        check_model(tag);
        @(negedge clk);
        wb_we = 1'b0; retire = 1'b0;
    endtask

    task automatic filler(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            if (a == 5'd3 || a == 5'd26 || a == 5'd27) a = 5'd0;
            step(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), tag);
        end
    endtask

    task automatic reset_now(input string tag);
        rst = 1'b0; wb_we = 1'b0; retire = 1'b0;
        #1;
        m_reset();
        check_model(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [63:0] rtn;

        // T1: pass path, cycle-accurate latency and count
        reset_now("rst0");
        filler(5, "t1a");
        step(1'b1, 5'd27, 64'd1, 1'b1, "t1_x27");
        filler(3, "t1b");
        step(1'b1, 5'd26, 64'd1, 1'b0, "t1_x26");
        chk("t1_pass", 64'(pass), 64'd1);
        chk("t1_fail", 64'(fail), 64'd0);
        chk("t1_ftn",  fail_testnum, 64'd0);
        chk("t1_cyc",  64'(cycle_cnt), 64'd10);
        filler(3, "t1c");

        // T2: fail path captures test number
        reset_now("rst2");
        filler(3, "t2a");
        step(1'b1, 5'd3, 64'd7, 1'b1, "t2_x3");
        filler(2, "t2b");
        step(1'b1, 5'd27, 64'd0, 1'b0, "t2_x27");
        filler(2, "t2c");
        step(1'b1, 5'd26, 64'd1, 1'b1, "t2_x26");
        chk("t2_fail", 64'(fail), 64'd1);
        chk("t2_pass", 64'(pass), 64'd0);
        chk("t2_ftn",  fail_testnum, 64'd7);

        // T3: DONE with data != 1 (incl. upper bits) is ignored; then pass
        reset_now("rst3");
        step(1'b1, 5'd27, 64'd1, 1'b0, "t3_x27");
        step(1'b1, 5'd26, 64'd2, 1'b1, "t3_x26a");
        step(1'b1, 5'd26, 64'h1_0000_0001, 1'b1, "t3_x26b");
        filler(2, "t3a");
        chk("t3_nodone", 64'(done), 64'd0);
        step(1'b1, 5'd26, 64'd1, 1'b0, "t3_x26c");
        chk("t3_pass", 64'(pass), 64'd1);

        // T3b: pass flag with upper bits set is not a pass
        reset_now("rst3b");
        rtn = {$urandom, $urandom};
        step(1'b1, 5'd3, rtn, 1'b0, "t3b_x3");
        step(1'b1, 5'd27, 64'h1_0000_0001, 1'b1, "t3b_x27");
        step(1'b1, 5'd26, 64'd1, 1'b0, "t3b_x26");
        chk("t3b_fail", 64'(fail), 64'd1);
        chk("t3b_ftn",  fail_testnum, rtn);

        // T4: watchdog (or indefinite wait without it)
        reset_now("rst4");
        filler(2, "t4a");
        step(1'b1, 5'd3, 64'd4, 1'b1, "t4_x3");
`ifdef TEST_MON_WATCHDOG_EN
        filler(57, "t4b");
        chk("t4_timeout", 64'(timeout), 64'd1);
        chk("t4_fail",    64'(fail), 64'd1);
        chk("t4_ftn",     fail_testnum, 64'd4);
        chk("t4_cyc",     64'(cycle_cnt), 64'd50);
`else
        filler(997, "t4b");
        chk("t4_run", 64'(done), 64'd0);
        chk("t4_cyc", 64'(cycle_cnt), 64'd1000);
`endif

        // T4b: DONE write on the watchdog expiry cycle wins
        reset_now("rst4b");
        step(1'b1, 5'd27, 64'd1, 1'b0, "t4b_x27");
        filler(48, "t4b_f");
        step(1'b1, 5'd26, 64'd1, 1'b1, "t4b_x26");
        chk("t4b_pass", 64'(pass), 64'd1);
        chk("t4b_tmo",  64'(timeout), 64'd0);
        chk("t4b_cyc",  64'(cycle_cnt), 64'd50);

        // T5: x0 writes ignored; terminal state frozen
        reset_now("rst5");
        for (int i = 0; i < 4; i++) step(1'b1, 5'd0, 64'd1, 1'b1, "t5_x0");
        step(1'b1, 5'd27, 64'd1, 1'b0, "t5_x27");
        step(1'b1, 5'd0, 64'd1, 1'b1, "t5_x0b");
        step(1'b1, 5'd26, 64'd1, 1'b1, "t5_x26");
        chk("t5_pass", 64'(pass), 64'd1);
        sv_cyc = 64'(cycle_cnt);
        sv_ret = 64'(retire_cnt);
        step(1'b1, 5'd27, 64'd0, 1'b1, "t5_post27");
        filler(5, "t5_post");
        step(1'b1, 5'd26, 64'd1, 1'b1, "t5_post26");
        chk("t5_frz_pass", 64'(pass), 64'd1);
        chk("t5_frz_ret",  64'(retire_cnt), sv_ret);
        chk("t5_frz_cyc",  64'(cycle_cnt), sv_cyc);

        // T6: reset mid-run, after pass, then a clean fresh test
        reset_now("rst6");
        filler(20, "t6a");
        reset_now("t6_mid");
        step(1'b1, 5'd27, 64'd1, 1'b1, "t6_x27");
        step(1'b1, 5'd26, 64'd1, 1'b1, "t6_x26");
        chk("t6_pass", 64'(pass), 64'd1);
        reset_now("t6_post");
        step(1'b1, 5'd3, 64'd9, 1'b0, "t6_x3");
        step(1'b1, 5'd26, 64'd1, 1'b1, "t6_x26b");
        chk("t6_fresh_fail", 64'(fail), 64'd1);
        chk("t6_fresh_ftn",  fail_testnum, 64'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
